complex_sweep: RTL and testbench
================================

Name: complex_sweep

Overview:
- Stimulus and capture stage wrapped around the combinational `complex` block (x[7:0], y[7:0] -> out).
- On a start pulse it drives a decrementing operand sweep on x/y, starting from loaded seeds. This is the same x-1/y-1 stepping used at bench level, now in hardware.
- It waits a programmable settle time and samples `complex.out` each step.
- It reports a hit count and the last 8 result bits, then pulses done.

Parameters:
- WIDTH, 8: operand width of x/y; must match `complex`.
- SETTLE, 1: idle cycles between driving an operand pair and sampling out_in; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only when busy=0.
- abort  in  1  synchronous; ends a running sweep with no done pulse.
- x_init  in  WIDTH  first x operand.
- y_init  in  WIDTH  first y operand.
- len  in  WIDTH  number of steps minus 1 (0 -> 1 step, 255 -> 256 steps); sampled at start.
- out_in  in  1  result from `complex.out`.
- x  out  WIDTH  registered operand to `complex.x`.
- y  out  WIDTH  registered operand to `complex.y`.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.
- hits  out  WIDTH+1  count of sampled out_in=1 in the current/last sweep.
- last_bits  out  8  shift register of sampled results; newest in bit 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; x, y, hits, last_bits = 0; busy=0; done=0; internal counters 0.
- FSM states: IDLE, WAIT, SAMPLE.
- IDLE with start=1 (at that edge):
  - Load x<=x_init, y<=y_init, remaining<=len.
  - Clear hits and last_bits; set busy<=1.
  - Go to WAIT with settle counter<=SETTLE-1. If SETTLE=0, go directly to SAMPLE.
- WAIT: decrement settle counter each cycle; when it is 0, go to SAMPLE. WAIT therefore occupies exactly SETTLE cycles.
- SAMPLE (one cycle), at its edge:
  - hits<=hits+out_in.
  - last_bits<={last_bits[6:0], out_in}.
  - If remaining=0: done<=1, busy<=0, go to IDLE. x/y hold their final values.
  - Else: x<=x-1, y<=y-1 (mod 2^WIDTH; 0x00 wraps to 0xFF), remaining<=remaining-1, reload settle counter, go to WAIT (or stay in SAMPLE if SETTLE=0).
- Timing:
  - Each step takes SETTLE+1 cycles.
  - done rises at edge number (len+1)*(SETTLE+1) counted after the start edge.
  - done stays high for exactly 1 cycle.
- Start/abort arbitration:
  - start while busy=1 is ignored.
  - start during the done cycle is accepted (state is already IDLE).
  - abort in WAIT or SAMPLE: go to IDLE, busy<=0, no done pulse. hits, last_bits, x, y hold partial values. Any sample scheduled at that edge is discarded.
  - abort in IDLE has no effect. abort has priority over start.
- hits cannot overflow: the maximum is 256 and it fits in WIDTH+1 bits.
- hits and last_bits hold their values after done until the next accepted start.
- Reset asserted mid-sweep returns everything to reset values immediately, with no done pulse.

Test Plan:
1. SETTLE=1; stub out_in=(x>y). Start with x_init=0xAF, y_init=0xAE, len=3.
   -> x/y go AF/AE, AE/AD, AD/AC, AC/AB.
   -> done at edge 8 after start; hits=4, last_bits=0x0F; busy high edges 1..8.
2. Wrap-around: x_init=0x01, y_init=0x00, len=2, same stub.
   -> pairs 01/00, 00/FF, FF/FE.
   -> results 1,0,1; hits=2, last_bits=0x05; final x=0xFF, y=0xFE.
3. SETTLE=0, len=255, stub out_in=1.
   -> one sample per cycle; done 256 edges after start; hits=256 (0x100), last_bits=0xFF.
4. Start during the sweep, and start in the done cycle:
   -> mid-sweep start is ignored (sample sequence unchanged).
   -> start coincident with done launches a new sweep, clearing hits to 0 at the next edge.
5. Abort after 2 samples of a len=5 run:
   -> busy falls and done never pulses; hits/last_bits keep the 2-sample values.
   -> abort with start in the same cycle while IDLE does nothing.
6. Assert rst_n low asynchronously mid-WAIT:
   -> x, y, hits, last_bits, busy, done read 0 before the next clock edge.
   -> a fresh start after release runs normally.

Source files
------------

// File: rtl/complex_sweep.sv
// Operand sweep driver and result capture around the combinational `complex` block.
// Steps x/y downward from loaded seeds, settles, samples out_in, and reports hits/last_bits.
module complex_sweep #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] x_init,
  input  logic [WIDTH-1:0] y_init,
  input  logic [WIDTH-1:0] len,
  input  logic             out_in,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   hits,
  output logic [7:0]       last_bits
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SAMPLE} state_e;

  localparam logic [3:0]       SETTLE_LOAD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, rem_q, rem_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH:0]   hits_q, hits_d;
  logic [7:0]       last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      rem_q    <= '0;
      settle_q <= '0;
      hits_q   <= '0;
      last_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rem_q    <= rem_d;
      settle_q <= settle_d;
      hits_q   <= hits_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // abort outranks both start and any sample due at the same edge
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    rem_d    = rem_q;
    settle_d = settle_q;
    hits_d   = hits_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          x_d      = x_init;
          y_d      = y_init;
          rem_d    = len;
          hits_d   = '0;
          last_d   = '0;
          busy_d   = 1'b1;
          settle_d = SETTLE_LOAD;
          if (SETTLE > 0) state_d = ST_WAIT;
          else            state_d = ST_SAMPLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (settle_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          hits_d = hits_q + {{WIDTH{1'b0}}, out_in};
          last_d = {last_q[6:0], out_in};
          if (rem_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            x_d      = x_q - ONE;
            y_d      = y_q - ONE;
            rem_d    = rem_q - ONE;
            settle_d = SETTLE_LOAD;
            if (SETTLE > 0) state_d = ST_WAIT;
            else            state_d = ST_SAMPLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign x         = x_q;
  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hits      = hits_q;
  assign last_bits = last_q;

endmodule

// File: tb/tb_complex_sweep.sv
// Bench for complex_sweep: two instances (SETTLE=1 and SETTLE=0) share stimulus and
// are compared every cycle against a step-counting model, plus directed literal checks.
module tb_complex_sweep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] x_init, y_init, len;
  logic       stub_mode;
  logic       cmp_en;

  logic [7:0] x_s1, y_s1, last_s1, x_s0, y_s0, last_s0;
  logic [8:0] hits_s1, hits_s0;
  logic       busy_s1, done_s1, busy_s0, done_s0;
  logic       out_s1, out_s0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // stand-in for `complex`: x>y, or constant 1
  assign out_s1 = stub_mode ? 1'b1 : (x_s1 > y_s1);
  assign out_s0 = stub_mode ? 1'b1 : (x_s0 > y_s0);

  complex_sweep #(.WIDTH(8), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_init(x_init), .y_init(y_init), .len(len), .out_in(out_s1),
    .x(x_s1), .y(y_s1), .busy(busy_s1), .done(done_s1),
    .hits(hits_s1), .last_bits(last_s1)
  );

  complex_sweep #(.WIDTH(8), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_init(x_init), .y_init(y_init), .len(len), .out_in(out_s0),
    .x(x_s0), .y(y_s0), .busy(busy_s0), .done(done_s0),
    .hits(hits_s0), .last_bits(last_s0)
  );

  // model: index 0 -> SETTLE=1 instance, index 1 -> SETTLE=0 instance
  logic [7:0] m_x[2], m_y[2], m_last[2], m_len[2];
  logic [8:0] m_hits[2];
  logic       m_busy[2], m_done[2];
  int         m_k[2], m_samples[2];
  logic       m_r;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // edges since the start edge; a sample lands on every (SETTLE+1)th edge
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_x[i] = 8'h00; m_y[i] = 8'h00; m_last[i] = 8'h00; m_len[i] = 8'h00;
        m_hits[i] = 9'h000; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        m_k[i] = 0; m_samples[i] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          if (abort) begin
            m_busy[i] = 1'b0;
          end else begin
            m_k[i]++;
            if (m_k[i] % (settle_of(i) + 1) == 0) begin
              m_r = stub_mode | (m_x[i] > m_y[i]);
              m_hits[i] = m_hits[i] + 9'(m_r);
              m_last[i] = {m_last[i][6:0], m_r};
              m_samples[i]++;
              if (m_samples[i] == int'(m_len[i]) + 1) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
              end else begin
                m_x[i] = m_x[i] - 8'd1;
                m_y[i] = m_y[i] - 8'd1;
              end
            end
          end
        end else if (start && !abort) begin
          m_x[i] = x_init; m_y[i] = y_init; m_len[i] = len;
          m_hits[i] = 9'h000; m_last[i] = 8'h00; m_busy[i] = 1'b1;
          m_k[i] = 0; m_samples[i] = 0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("s1.x", 32'(x_s1), 32'(m_x[0]));
      check_output("s1.y", 32'(y_s1), 32'(m_y[0]));
      check_output("s1.busy", 32'(busy_s1), 32'(m_busy[0]));
      check_output("s1.done", 32'(done_s1), 32'(m_done[0]));
      check_output("s1.hits", 32'(hits_s1), 32'(m_hits[0]));
      check_output("s1.last_bits", 32'(last_s1), 32'(m_last[0]));
      check_output("s0.x", 32'(x_s0), 32'(m_x[1]));
      check_output("s0.y", 32'(y_s0), 32'(m_y[1]));
      check_output("s0.busy", 32'(busy_s0), 32'(m_busy[1]));
      check_output("s0.done", 32'(done_s0), 32'(m_done[1]));
      check_output("s0.hits", 32'(hits_s0), 32'(m_hits[1]));
      check_output("s0.last_bits", 32'(last_s0), 32'(m_last[1]));
    end
  end

  // returns at the falling edge just after the start edge (edge 0)
  task automatic apply_stimulus(input logic [7:0] xi, input logic [7:0] yi, input logic [7:0] l);
    @(negedge clk);
    x_init = xi; y_init = yi; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    x_init = 8'h00; y_init = 8'h00; len = 8'h00;
    stub_mode = 1'b0; cmp_en = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset x", 32'(x_s1), 32'h0);
    check_output("reset hits", 32'(hits_s1), 32'h0);
    check_output("reset last_bits", 32'(last_s1), 32'h0);
    check_output("reset busy", 32'(busy_s1), 32'h0);
    check_output("reset done", 32'(done_s1), 32'h0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    $display("[TB] basic sweep AF/AE len=3");
    apply_stimulus(8'hAF, 8'hAE, 8'd3);
    check_output("t1 x0", 32'(x_s1), 32'hAF);
    check_output("t1 y0", 32'(y_s1), 32'hAE);
    check_output("t1 busy0", 32'(busy_s1), 32'h1);
    repeat (2) @(negedge clk);
    check_output("t1 x1", 32'(x_s1), 32'hAE);
    check_output("t1 y1", 32'(y_s1), 32'hAD);
    repeat (2) @(negedge clk);
    check_output("t1 x2", 32'(x_s1), 32'hAD);
    repeat (2) @(negedge clk);
    check_output("t1 x3", 32'(x_s1), 32'hAC);
    check_output("t1 y3", 32'(y_s1), 32'hAB);
    @(negedge clk);
    check_output("t1 done early", 32'(done_s1), 32'h0);
    check_output("t1 busy7", 32'(busy_s1), 32'h1);
    @(negedge clk);
    check_output("t1 done", 32'(done_s1), 32'h1);
    check_output("t1 busy end", 32'(busy_s1), 32'h0);
    check_output("t1 hits", 32'(hits_s1), 32'h4);
    check_output("t1 last_bits", 32'(last_s1), 32'h0F);
    check_output("t1 x final", 32'(x_s1), 32'hAC);
    @(negedge clk);
    check_output("t1 done width", 32'(done_s1), 32'h0);
    check_output("t1 hits hold", 32'(hits_s1), 32'h4);

    $display("[TB] wrap-around 01/00 len=2");
    apply_stimulus(8'h01, 8'h00, 8'd2);
    repeat (6) @(negedge clk);
    check_output("t2 done", 32'(done_s1), 32'h1);
    check_output("t2 hits", 32'(hits_s1), 32'h2);
    check_output("t2 last_bits", 32'(last_s1), 32'h05);
    check_output("t2 x", 32'(x_s1), 32'hFF);
    check_output("t2 y", 32'(y_s1), 32'hFE);
    check_output("t2 s0 hits", 32'(hits_s0), 32'h2);
    check_output("t2 s0 x", 32'(x_s0), 32'hFF);

    $display("[TB] full-length sweep len=255");
    @(negedge clk);
    stub_mode = 1'b1;
    apply_stimulus(8'h10, 8'h10, 8'hFF);
    repeat (256) @(negedge clk);
    check_output("t3 s0 done", 32'(done_s0), 32'h1);
    check_output("t3 s0 hits", 32'(hits_s0), 32'h100);
    check_output("t3 s0 last_bits", 32'(last_s0), 32'hFF);
    check_output("t3 s1 busy", 32'(busy_s1), 32'h1);
    repeat (256) @(negedge clk);
    check_output("t3 s1 done", 32'(done_s1), 32'h1);
    check_output("t3 s1 hits", 32'(hits_s1), 32'h100);
    stub_mode = 1'b0;

    $display("[TB] start arbitration");
    apply_stimulus(8'h50, 8'h40, 8'd3);
    repeat (2) @(negedge clk);
    x_init = 8'h10; y_init = 8'h20; len = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("t4 done", 32'(done_s1), 32'h1);
    check_output("t4 hits", 32'(hits_s1), 32'h4);
    check_output("t4 x", 32'(x_s1), 32'h4D);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("t4 restart hits", 32'(hits_s1), 32'h0);
    check_output("t4 restart busy", 32'(busy_s1), 32'h1);
    check_output("t4 restart x", 32'(x_s1), 32'h10);
    check_output("t4 restart done", 32'(done_s1), 32'h0);
    repeat (4) @(negedge clk);
    check_output("t4 second done", 32'(done_s1), 32'h1);
    check_output("t4 second last_bits", 32'(last_s1), 32'h00);

    $display("[TB] abort after two samples");
    apply_stimulus(8'h30, 8'h20, 8'd5);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("t5 busy", 32'(busy_s1), 32'h0);
    check_output("t5 hits", 32'(hits_s1), 32'h2);
    check_output("t5 last_bits", 32'(last_s1), 32'h03);
    check_output("t5 x", 32'(x_s1), 32'h2E);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("t5 no done", 32'(done_s1), 32'h0);
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_output("t5 abort+start busy", 32'(busy_s1), 32'h0);
    check_output("t5 abort+start hits", 32'(hits_s1), 32'h2);

    $display("[TB] asynchronous reset mid-wait");
    apply_stimulus(8'h77, 8'h11, 8'd4);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("t6 x", 32'(x_s1), 32'h0);
    check_output("t6 y", 32'(y_s1), 32'h0);
    check_output("t6 hits", 32'(hits_s1), 32'h0);
    check_output("t6 last_bits", 32'(last_s1), 32'h0);
    check_output("t6 busy", 32'(busy_s1), 32'h0);
    check_output("t6 done", 32'(done_s1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(8'h05, 8'h03, 8'd1);
    repeat (4) @(negedge clk);
    check_output("t6 rerun done", 32'(done_s1), 32'h1);
    check_output("t6 rerun hits", 32'(hits_s1), 32'h2);
    check_output("t6 rerun last_bits", 32'(last_s1), 32'h03);
    check_output("t6 rerun x", 32'(x_s1), 32'h04);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
